// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the multi-buffered, upscaling frame buffer.
// Double-buffer swap states, RGB565 expansion and low-res geometry helpers.
package frame_buffer_pkg;

  typedef enum logic {WRITING, WAIT_SWAP} swap_state_t;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
    return {pix[15:11], 3'b000, pix[10:5], 2'b00, pix[4:0], 3'b000};
  endfunction

  function automatic int scaled_dim(input int full_dim, input int shift);
    return full_dim >> shift;
  endfunction

  function automatic int buffer_depth(input int full_w, input int full_h, input int shift);
    return scaled_dim(full_w, shift) * scaled_dim(full_h, shift);
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Buffer role bookkeeping: write/display/spare indices, write handshake,
// end-of-video-frame swaps and the saturating dropped-frame counter.
module fb_swap_ctrl #(
  parameter int NUM_BUFFERS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ray_valid,
  input  logic        ray_last,
  input  logic        video_last,
  output logic        ray_ready,
  output logic [1:0]  write_idx,
  output logic [1:0]  display_idx,
  output logic        frame_swap,
  output logic [15:0] frame_drop_count
);
  import frame_buffer_pkg::*;

  swap_state_t state;
  logic [1:0]  spare_idx;
  logic        ready_valid;
  logic        last_done;
  logic        drop_inc;

  assign last_done = ray_valid && ray_ready && ray_last;
  assign drop_inc  = ready_valid && (frame_drop_count != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= WRITING;
      ready_valid      <= 1'b0;
      write_idx        <= 2'd0;
      display_idx      <= 2'd1;
      spare_idx        <= 2'd2;
      ray_ready        <= 1'b0;
      frame_swap       <= 1'b0;
      frame_drop_count <= '0;
    end else begin
      frame_swap <= 1'b0;
      if (NUM_BUFFERS == 3) begin
        ray_ready <= 1'b1;
        if (last_done && video_last) begin
          // Finished frame goes straight to display; old display becomes spare.
          display_idx <= write_idx;
          write_idx   <= spare_idx;
          spare_idx   <= display_idx;
          if (drop_inc) frame_drop_count <= frame_drop_count + 16'd1;
          ready_valid <= 1'b0;
          frame_swap  <= 1'b1;
        end else if (last_done) begin
          write_idx   <= spare_idx;
          spare_idx   <= write_idx;
          if (drop_inc) frame_drop_count <= frame_drop_count + 16'd1;
          ready_valid <= 1'b1;
        end else if (video_last && ready_valid) begin
          display_idx <= spare_idx;
          spare_idx   <= display_idx;
          ready_valid <= 1'b0;
          frame_swap  <= 1'b1;
        end
      end else begin
        case (state)
          WRITING: begin
            ray_ready <= 1'b1;
            if (last_done) begin
              if (video_last) begin
                write_idx   <= display_idx;
                display_idx <= write_idx;
                frame_swap  <= 1'b1;
              end else begin
                state     <= WAIT_SWAP;
                ray_ready <= 1'b0;
              end
            end
          end
          WAIT_SWAP: begin
            if (video_last) begin
              write_idx   <= display_idx;
              display_idx <= write_idx;
              frame_swap  <= 1'b1;
              ray_ready   <= 1'b1;
              state       <= WRITING;
            end
          end
          default: state <= WRITING;
        endcase
      end
    end
  end

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; HIGH_PERFORMANCE adds an output register (latency 2).
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 16,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) bram[addra] <= dina;
      ram_data <= bram[addra];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_output_reg
    assign douta = ram_data;
  end else begin : g_output_reg
    logic [RAM_WIDTH-1:0] douta_reg;
    always_ff @(posedge clka) begin
      if (rsta) douta_reg <= '0;
      else if (regcea) douta_reg <= ram_data;
    end
    assign douta = douta_reg;
  end

endmodule

// File: rtl/frame_buffer_multi.sv
// Double/triple-buffered low-res frame store feeding HDMI, upscaled by 2^SCALE_SHIFT.
// Display index and active flag travel with the read so swaps never show stale pixels.
module frame_buffer_multi
  import frame_buffer_pkg::*;
#(
  parameter int PIXEL_WIDTH        = 16,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int SCALE_SHIFT        = 2,
  parameter int NUM_BUFFERS        = 2,
  parameter int RAM_LATENCY        = 2,
  localparam int SW     = scaled_dim(FULL_SCREEN_WIDTH, SCALE_SHIFT),
  localparam int DEPTH  = buffer_depth(FULL_SCREEN_WIDTH, FULL_SCREEN_HEIGHT, SCALE_SHIFT),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   ray_valid_in,
  input  logic [ADDR_W-1:0]      ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  output logic                   ray_ready_out,
  input  logic                   video_last_pixel_in,
  output logic [23:0]            rgb_out,
  output logic                   frame_swap_out,
  output logic [15:0]            frame_drop_count_out
);

  logic [1:0]             write_idx;
  logic [1:0]             display_idx;
  logic                   beat_write;
  logic                   active;
  logic [ADDR_W-1:0]      read_addr;
  logic [PIXEL_WIDTH-1:0] ram_dout [NUM_BUFFERS];
  logic [PIXEL_WIDTH-1:0] sel_pixel;
  logic [23:0]            pixel_rgb;
  logic                   active_pipe [RAM_LATENCY];
  logic [1:0]             disp_pipe [RAM_LATENCY];

  fb_swap_ctrl #(.NUM_BUFFERS(NUM_BUFFERS)) u_ctrl (
    .clk              (pixel_clk_in),
    .rst_n            (rst_n_in),
    .ray_valid        (ray_valid_in),
    .ray_last         (ray_last_pixel_in),
    .video_last       (video_last_pixel_in),
    .ray_ready        (ray_ready_out),
    .write_idx        (write_idx),
    .display_idx      (display_idx),
    .frame_swap       (frame_swap_out),
    .frame_drop_count (frame_drop_count_out)
  );

  // Out-of-range beats are still handshaken; they just never reach a RAM.
  assign beat_write = ray_valid_in && ray_ready_out && (32'(ray_address_in) < 32'(DEPTH));
  assign read_addr  = ADDR_W'(32'(hcount_in >> SCALE_SHIFT) + 32'(SW) * 32'(vcount_in >> SCALE_SHIFT));
  assign active     = (32'(hcount_in) < 32'(FULL_SCREEN_WIDTH)) && (32'(vcount_in) < 32'(FULL_SCREEN_HEIGHT));

  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
    logic sel_write;
    assign sel_write = (write_idx == 2'(i));
    xilinx_single_port_ram_read_first #(
      .RAM_WIDTH       (PIXEL_WIDTH),
      .RAM_DEPTH       (DEPTH),
      .RAM_PERFORMANCE ((RAM_LATENCY == 1) ? "LOW_LATENCY" : "HIGH_PERFORMANCE")
    ) u_ram (
      .addra  (sel_write ? ray_address_in : read_addr),
      .dina   (ray_pixel_in),
      .clka   (pixel_clk_in),
      .wea    (beat_write && sel_write),
      .ena    (1'b1),
      .rsta   (1'b0),
      .regcea (1'b1),
      .douta  (ram_dout[i])
    );
  end

  always_comb begin
    sel_pixel = ram_dout[0];
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      if (disp_pipe[RAM_LATENCY-1] == 2'(b)) sel_pixel = ram_dout[b];
    end
  end

  if (PIXEL_WIDTH == 16) begin : g_rgb565
    assign pixel_rgb = rgb565_to_888(sel_pixel);
  end else if (PIXEL_WIDTH == 24) begin : g_rgb888
    assign pixel_rgb = sel_pixel;
  end else begin : g_bad_width
    $error("frame_buffer_multi: PIXEL_WIDTH must be 16 or 24");
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < RAM_LATENCY; k++) begin
        active_pipe[k] <= 1'b0;
        disp_pipe[k]   <= 2'd0;
      end
      rgb_out <= 24'd0;
    end else begin
      active_pipe[0] <= active;
      disp_pipe[0]   <= display_idx;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        active_pipe[k] <= active_pipe[k-1];
        disp_pipe[k]   <= disp_pipe[k-1];
      end
      rgb_out <= active_pipe[RAM_LATENCY-1] ? pixel_rgb : 24'd0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Directed bench: one double-buffer and one triple-buffer instance driven side by side.
module tb_frame_buffer_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  logic        d_valid, d_last, d_vlast, d_ready, d_swap;
  logic [15:0] d_addr, d_pixel, d_drops;
  logic [23:0] d_rgb;

  logic        t_valid, t_last, t_vlast, t_ready, t_swap;
  logic [15:0] t_addr, t_pixel, t_drops;
  logic [23:0] t_rgb;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  always #5 clk = ~clk;

  frame_buffer_multi #(.NUM_BUFFERS(2)) u_double (
    .pixel_clk_in         (clk),
    .rst_n_in             (rst_n),
    .hcount_in            (hcount),
    .vcount_in            (vcount),
    .ray_valid_in         (d_valid),
    .ray_address_in       (d_addr),
    .ray_pixel_in         (d_pixel),
    .ray_last_pixel_in    (d_last),
    .ray_ready_out        (d_ready),
    .video_last_pixel_in  (d_vlast),
    .rgb_out              (d_rgb),
    .frame_swap_out       (d_swap),
    .frame_drop_count_out (d_drops)
  );

  frame_buffer_multi #(.NUM_BUFFERS(3)) u_triple (
    .pixel_clk_in         (clk),
    .rst_n_in             (rst_n),
    .hcount_in            (hcount),
    .vcount_in            (vcount),
    .ray_valid_in         (t_valid),
    .ray_address_in       (t_addr),
    .ray_pixel_in         (t_pixel),
    .ray_last_pixel_in    (t_last),
    .ray_ready_out        (t_ready),
    .video_last_pixel_in  (t_vlast),
    .rgb_out              (t_rgb),
    .frame_swap_out       (t_swap),
    .frame_drop_count_out (t_drops)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit triple, input logic valid, input logic [15:0] addr,
                               input logic [15:0] pixel, input logic last, input logic vlast);
    if (triple) begin
      t_valid = valid; t_addr = addr; t_pixel = pixel; t_last = last; t_vlast = vlast;
    end else begin
      d_valid = valid; d_addr = addr; d_pixel = pixel; d_last = last; d_vlast = vlast;
    end
    tick();
    d_valid = 1'b0; d_last = 1'b0; d_vlast = 1'b0;
    t_valid = 1'b0; t_last = 1'b0; t_vlast = 1'b0;
  endtask

  task automatic checkPixel(input string tag, input bit triple, input int h, input int v, input logic [23:0] expected);
    hcount = 11'(h);
    vcount = 10'(v);
    repeat (3) tick();
    checkOutput(tag, triple ? 32'(t_rgb) : 32'(d_rgb), 32'(expected));
  endtask

  function automatic logic [31:0] d_roles();
    return 32'({u_double.u_ctrl.write_idx, u_double.u_ctrl.display_idx, u_double.u_ctrl.spare_idx});
  endfunction

  function automatic logic [31:0] t_roles();
    return 32'({u_triple.u_ctrl.write_idx, u_triple.u_ctrl.display_idx, u_triple.u_ctrl.spare_idx});
  endfunction

  initial begin
    rst_n = 1'b0; hcount = 11'd1500; vcount = 10'd0;
    d_valid = 0; d_addr = 0; d_pixel = 0; d_last = 0; d_vlast = 0;
    t_valid = 0; t_addr = 0; t_pixel = 0; t_last = 0; t_vlast = 0;
    repeat (2) tick();
    $display("[TB] reset state");
    checkOutput("rst_d_rgb", 32'(d_rgb), 32'h0);
    checkOutput("rst_d_ready", 32'(d_ready), 32'h0);
    checkOutput("rst_d_swap", 32'(d_swap), 32'h0);
    checkOutput("rst_d_roles", d_roles(), 32'b00_01_10);
    checkOutput("rst_t_drops", 32'(t_drops), 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_d_ready", 32'(d_ready), 32'h1);
    checkOutput("rel_t_ready", 32'(t_ready), 32'h1);

    $display("[TB] double mode full sweep");
    for (int b = 0; b < 57600; b++) applyStimulus(1'b0, 1'b1, 16'(b), 16'(b), b == 57599, 1'b0);
    checkOutput("sweep_ready_drop", 32'(d_ready), 32'h0);
    checkOutput("sweep_no_swap", 32'(d_swap), 32'h0);
    checkOutput("sweep_roles_hold", d_roles(), 32'b00_01_10);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("vlast_swap_pulse", 32'(d_swap), 32'h1);
    checkOutput("vlast_ready", 32'(d_ready), 32'h1);
    checkOutput("vlast_roles", d_roles(), 32'b01_00_10);
    tick();
    checkOutput("swap_pulse_end", 32'(d_swap), 32'h0);
    checkPixel("pix_4_0", 1'b0, 4, 0, 24'h000008);
    checkPixel("pix_0_4", 1'b0, 0, 4, 24'h002800);
    checkPixel("pix_last", 1'b0, 1279, 719, 24'hE01CF8);
    checkPixel("blank_h1280", 1'b0, 1280, 0, 24'h000000);
    checkPixel("blank_v720", 1'b0, 0, 720, 24'h000000);

    $display("[TB] out-of-range write");
    applyStimulus(1'b0, 1'b1, 16'd57600, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("oor_roles", d_roles(), 32'b01_00_10);
    checkOutput("oor_no_swap", 32'(d_swap), 32'h0);
    checkOutput("oor_ready", 32'(d_ready), 32'h1);

    $display("[TB] double mode simultaneous last and video_last");
    applyStimulus(1'b0, 1'b1, 16'd0, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'd1, 16'hF800, 1'b1, 1'b1);
    checkOutput("sim_swap", 32'(d_swap), 32'h1);
    checkOutput("sim_ready", 32'(d_ready), 32'h1);
    checkOutput("sim_roles", d_roles(), 32'b00_01_10);
    checkPixel("sim_pix0", 1'b0, 0, 0, 24'h1044A0);
    checkPixel("sim_pix1", 1'b0, 4, 0, 24'hF80000);

    $display("[TB] triple mode");
    applyStimulus(1'b1, 1'b1, 16'd0, 16'h001F, 1'b1, 1'b0);
    checkOutput("t_a_ready", 32'(t_ready), 32'h1);
    checkOutput("t_a_roles", t_roles(), 32'b10_01_00);
    checkOutput("t_a_drops", 32'(t_drops), 32'h0);
    applyStimulus(1'b1, 1'b1, 16'd0, 16'h07E0, 1'b1, 1'b0);
    checkOutput("t_b_drops", 32'(t_drops), 32'h1);
    checkOutput("t_b_roles", t_roles(), 32'b00_01_10);
    checkOutput("t_b_no_swap", 32'(t_swap), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("t_vl_swap", 32'(t_swap), 32'h1);
    checkOutput("t_vl_roles", t_roles(), 32'b00_10_01);
    checkPixel("t_show_b", 1'b1, 0, 0, 24'h00FC00);
    applyStimulus(1'b1, 1'b1, 16'd0, 16'hF800, 1'b1, 1'b0);
    checkOutput("t_c_roles", t_roles(), 32'b01_10_00);
    applyStimulus(1'b1, 1'b1, 16'd0, 16'h001F, 1'b1, 1'b1);
    checkOutput("t_both_swap", 32'(t_swap), 32'h1);
    checkOutput("t_both_drops", 32'(t_drops), 32'h2);
    checkOutput("t_both_roles", t_roles(), 32'b00_01_10);
    checkPixel("t_show_d", 1'b1, 0, 0, 24'h0000F8);
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("t_vl_idle_swap", 32'(t_swap), 32'h0);
    checkOutput("t_vl_idle_roles", t_roles(), 32'b00_01_10);

    $display("[TB] reset mid-sweep");
    checkPixel("pre_rst_pix", 1'b0, 0, 0, 24'h1044A0);
    for (int b = 100; b < 104; b++) applyStimulus(1'b0, 1'b1, 16'(b), 16'hAAAA, 1'b0, 1'b0);
    rst_n = 1'b0; d_valid = 1'b1; d_addr = 16'd104; d_pixel = 16'hAAAA;
    tick();
    checkOutput("mrst_rgb", 32'(d_rgb), 32'h0);
    checkOutput("mrst_ready", 32'(d_ready), 32'h0);
    checkOutput("mrst_swap", 32'(d_swap), 32'h0);
    checkOutput("mrst_d_roles", d_roles(), 32'b00_01_10);
    checkOutput("mrst_t_roles", t_roles(), 32'b00_01_10);
    checkOutput("mrst_t_drops", 32'(t_drops), 32'h0);
    rst_n = 1'b1; d_valid = 1'b0;
    tick();
    checkOutput("mrst_ready_rise", 32'(d_ready), 32'h1);
    checkPixel("mrst_bram_kept", 1'b0, 0, 0, 24'h1044A0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
